oled_cmd_receiver: RTL and testbench
====================================

# oled_cmd_receiver

SPI responder modelling the command/data receive side of the Pmod OLED's SSD1306-class controller. It samples the 4-wire bus (CS, SCLK, MOSI, D/C) plus the OLED reset line driven by the power-on initiator, and assembles bytes. It decodes commands into a shadow register set and turns data bytes into addressed pixel-column writes. It serves as the on-chip bus-functional target for checking the initialiser, and as the front end of a frame-buffer mirror.

## Interface
- `SYNC_STAGES`, 2, synchroniser depth on all SPI inputs (≥2).
- `COLS`, 128, columns per page (power of two).
- `PAGES`, 8, pages (power of two).

- `clk` in 1: system clock; must be ≥4× SCLK frequency.
- `rst` in 1: synchronous, active-high reset.
- `spi_cs_n` in 1: chip select, active low, asynchronous to `clk`.
- `spi_sclk` in 1: serial clock, asynchronous to `clk`; SPI mode 0.
- `spi_mosi` in 1: serial data, MSB first.
- `spi_dc` in 1: 0 = command byte, 1 = data byte.
- `oled_res_n` in 1: OLED reset, active low.
- `byte_valid` out 1: one-cycle strobe, a byte was received.
- `byte_data` out 8: received byte; held until the next strobe.
- `byte_is_data` out 1: D/C value latched with the byte.
- `cmd_err` out 1: one-cycle strobe on an illegal or aborted command.
- `display_on` out 1: set by AF, cleared by AE.
- `charge_pump_en` out 1: set from 8D argument bit 2.
- `mux_ratio` out 6: A8 argument.
- `disp_offset` out 6: D3 argument.
- `start_line` out 6: from 40–7F.
- `addr_mode` out 2: 0 horizontal, 1 vertical, 2 page.
- `pix_we` out 1: one-cycle write strobe.
- `pix_page` out log2(PAGES): page address of the write.
- `pix_col` out log2(COLS): column address of the write.
- `pix_data` out 8: 8 vertical pixels, bit 0 at the top.

## Operation
- **Inputs:** every SPI input and `oled_res_n` passes through SYNC_STAGES flops. A rising edge on `spi_sclk` is detected from the last two synchronised samples.
- **Receiving bits:** on a detected rising edge with `spi_cs_n` low, MOSI shifts in and the bit counter (0–7) increments. On the eighth bit:
  - the byte is emitted;
  - `spi_dc` is latched;
  - the counter returns to 0.
- **Abort:** `spi_cs_n` high clears the bit counter and discards a partial byte, with no strobe. A pending command argument is kept across CS high.
- **Reset:** `oled_res_n` low (synchronised) has the same effect as `rst` on everything except the synchroniser flops.
- **Command FSM, CMD_IDLE:**
  - AE/AF set `display_on` to 0/1.
  - 40–7F set `start_line` = byte[5:0].
  - B0+p (p < PAGES) sets the page.
  - 00–0F sets the column low nibble.
  - 10–17 sets the column high bits [6:4] = byte[2:0].
  - A8, D3, 8D and 20 store the opcode and go to CMD_ARG.
  - Any other opcode pulses `cmd_err`; no state change.
- **Command FSM, CMD_ARG:** the next command byte is the argument; return to CMD_IDLE.
  - A8: accept if arg[5:0] ≥ 15, else `cmd_err` and keep the old value.
  - D3: `disp_offset` = arg[5:0].
  - 8D: `charge_pump_en` = arg[2].
  - 20: arg[1:0] = 3 gives `cmd_err` and keeps the old value.
- **Data byte while in CMD_ARG:** pulse `cmd_err`, drop the pending command, return to CMD_IDLE, and still perform the data write.
- **Data byte:** drive `pix_we` with the current page/column and the byte, then advance the pointer.
  - Horizontal: column+1; at COLS-1 the column wraps to 0 and page+1, with page wrapping PAGES-1 → 0.
  - Vertical: page+1; at PAGES-1 the page wraps to 0 and column+1, with column wrapping to 0.
  - Page mode: column+1 wrapping to 0; page unchanged.
- Changing `addr_mode` does not move the pointer.
- **Reset values:** all strobes 0, `byte_data` 0, `byte_is_data` 0, `display_on` 0, `charge_pump_en` 0, `mux_ratio` 63, `disp_offset` 0, `start_line` 0, `addr_mode` 2, page 0, column 0, FSM CMD_IDLE, bit counter 0.

## Timing
- `byte_valid` rises SYNC_STAGES+1 `clk` cycles after the eighth SCLK rising edge reaches the input pins.
- Register updates and `pix_we` appear exactly one cycle after `byte_valid`. The pointer increments on that same edge; `pix_page`/`pix_col` show the pre-increment address.
- Back-to-back bytes cannot overlap, given the ≥4× clock ratio: one byte spans ≥32 `clk`.
- `rst` takes priority over all events in the same cycle. Reset mid-byte or mid-argument discards the byte and the argument; no strobe is issued.
- No backpressure: a consumer of `pix_we` must accept one write per byte.

## Structure
- **Package `oled_pkg`:** opcode constants (AE, AF, A8, D3, 8D, 20, 40, B0), the addressing-mode enum, and the register reset values. The package is shared with the power-on initiator.
- **Sub-module `spi_byte_rx`:** synchroniser, edge detect, shift register and bit counter; outputs `byte_valid`/`byte_data`/`byte_is_data`.
- **Top level:** command FSM, shadow registers and address pointer.

## Test plan
- **Power-on sequence:** send AE, A8 3F, D3 00, 40, 8D 14, 20 00, AF. Expect:
  - `display_on` 1, `mux_ratio` 63, `charge_pump_en` 1, `addr_mode` 0, `cmd_err` never asserted;
  - 11 `byte_valid` strobes.
- **Horizontal wrap:** page 0, column 126; send 3 data bytes. Expect writes at (0,126), (0,127), (1,0).
- **Vertical wrap:** `addr_mode` 1, page 7, column 127; send 2 data bytes. Expect writes at (7,127), (0,0).
- **Illegal command handling:**
  - 20 03 gives `cmd_err` and `addr_mode` unchanged.
  - A8 05 gives `cmd_err` and `mux_ratio` unchanged.
  - Opcode E3 gives `cmd_err`.
  - A8 followed by a data byte 55 gives `cmd_err`, then a write of 55.
- **CS abort:** 5 bits, then CS high, then a full byte AF. Expect no strobe for the partial byte and `display_on` 1.
- **Reset during data stream:** `oled_res_n` low mid-byte. Expect every register back to its reset value and no `pix_we`; then `rst` held during SCLK activity gives the same result.

Source files
------------

// File: rtl/oled_pkg.sv
// Shared SSD1306-class opcode constants, addressing-mode enum and register reset values.
// Pure declarations; no latency of its own.
// No flow control; also used by the power-on initiator.
package oled_pkg;

    localparam logic [7:0] OP_DISP_OFF   = 8'hAE;
    localparam logic [7:0] OP_DISP_ON    = 8'hAF;
    localparam logic [7:0] OP_MUX_RATIO  = 8'hA8;
    localparam logic [7:0] OP_DISP_OFS   = 8'hD3;
    localparam logic [7:0] OP_CHG_PUMP   = 8'h8D;
    localparam logic [7:0] OP_ADDR_MODE  = 8'h20;
    localparam logic [7:0] OP_START_LINE = 8'h40;   // 40..7F, low 6 bits are the line
    localparam logic [7:0] OP_PAGE       = 8'hB0;   // B0+page

    typedef enum logic [1:0] {
        ADDR_HORIZ = 2'd0,
        ADDR_VERT  = 2'd1,
        ADDR_PAGE  = 2'd2
    } addr_mode_e;

    localparam logic [5:0] RST_MUX_RATIO  = 6'd63;
    localparam logic [5:0] RST_DISP_OFS   = 6'd0;
    localparam logic [5:0] RST_START_LINE = 6'd0;
    localparam addr_mode_e RST_ADDR_MODE  = ADDR_PAGE;

    // Smallest multiplex ratio the controller accepts (16 rows, encoded as 15).
    localparam logic [5:0] MUX_RATIO_MIN  = 6'd15;

    // Opcodes whose following command byte is an argument.
    function automatic logic takes_arg(input logic [7:0] op);
        return (op == OP_MUX_RATIO) || (op == OP_DISP_OFS) ||
               (op == OP_CHG_PUMP)  || (op == OP_ADDR_MODE);
    endfunction

endpackage

// File: rtl/spi_byte_rx.sv
// SPI mode-0 byte receiver: synchronises CS/SCLK/MOSI/DC/RES#, detects SCLK rises, assembles MSB-first bytes.
// byte_valid rises SYNC_STAGES+1 clk after the 8th SCLK rise at the pins; res_active lags oled_res_n by SYNC_STAGES.
// No backpressure: every completed byte is strobed once; CS high or reset drops a partial byte silently.
// Ports: clk/rst (sync, active high), raw SPI pins + oled_res_n in; res_active, byte_valid/byte_data/byte_is_data out.
module spi_byte_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_cs_n,
    input  logic       spi_sclk,
    input  logic       spi_mosi,
    input  logic       spi_dc,
    input  logic       oled_res_n,
    output logic       res_active,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       byte_is_data
);

    logic [SYNC_STAGES-1:0] cs_sync, sclk_sync, mosi_sync, dc_sync, res_sync;
    logic                   sclk_prev;
    logic [2:0]             bit_cnt;
    logic [6:0]             shreg;      // first seven bits; the eighth goes straight into byte_data
    logic                   sclk_rise;

    assign sclk_rise  = sclk_sync[SYNC_STAGES-1] & ~sclk_prev;
    assign res_active = ~res_sync[SYNC_STAGES-1];

    // Synchronisers and the edge-detect history keep running while the OLED reset is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            cs_sync   <= '1;
            sclk_sync <= '0;
            mosi_sync <= '0;
            dc_sync   <= '0;
            res_sync  <= '1;
            sclk_prev <= 1'b0;
        end else begin
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0],   spi_cs_n};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            dc_sync   <= {dc_sync[SYNC_STAGES-2:0],   spi_dc};
            res_sync  <= {res_sync[SYNC_STAGES-2:0],  oled_res_n};
            sclk_prev <= sclk_sync[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || res_active) begin
            bit_cnt      <= 3'd0;
            shreg        <= 7'd0;
            byte_valid   <= 1'b0;
            byte_data    <= 8'd0;
            byte_is_data <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            if (cs_sync[SYNC_STAGES-1]) begin
                bit_cnt <= 3'd0;
            end else if (sclk_rise) begin
                if (bit_cnt == 3'd7) begin
                    byte_data    <= {shreg, mosi_sync[SYNC_STAGES-1]};
                    byte_is_data <= dc_sync[SYNC_STAGES-1];
                    byte_valid   <= 1'b1;
                    bit_cnt      <= 3'd0;
                end else begin
                    shreg   <= {shreg[5:0], mosi_sync[SYNC_STAGES-1]};
                    bit_cnt <= bit_cnt + 3'd1;
                end
            end
        end
    end

endmodule

// File: rtl/oled_cmd_receiver.sv
// SSD1306-class receive model: decodes SPI command bytes into shadow registers and data bytes into pixel-column writes.
// Register updates and pix_we appear one clk after byte_valid; pix_page/pix_col carry the pre-increment address.
// No backpressure: the pix_we consumer must take one write per data byte.
// Ports: clk/rst, SPI pins, oled_res_n in; byte strobe/data, cmd_err, shadow registers and the pix_* write port out.
module oled_cmd_receiver
    import oled_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int COLS        = 128,
    parameter int PAGES       = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     spi_cs_n,
    input  logic                     spi_sclk,
    input  logic                     spi_mosi,
    input  logic                     spi_dc,
    input  logic                     oled_res_n,
    output logic                     byte_valid,
    output logic [7:0]               byte_data,
    output logic                     byte_is_data,
    output logic                     cmd_err,
    output logic                     display_on,
    output logic                     charge_pump_en,
    output logic [5:0]               mux_ratio,
    output logic [5:0]               disp_offset,
    output logic [5:0]               start_line,
    output logic [1:0]               addr_mode,
    output logic                     pix_we,
    output logic [$clog2(PAGES)-1:0] pix_page,
    output logic [$clog2(COLS)-1:0]  pix_col,
    output logic [7:0]               pix_data
);

    localparam int PW = $clog2(PAGES);
    localparam int CW = $clog2(COLS);
    localparam logic [4:0] PAGES_L = 5'(PAGES);

    typedef enum logic {CMD_IDLE, CMD_ARG} cmd_state_e;

    cmd_state_e    state;
    logic [7:0]    pend_op;
    addr_mode_e    mode_q;
    logic [PW-1:0] page;
    logic [CW-1:0] col;
    logic          res_active;
    logic [7:0]    col_lo_set, col_hi_set;
    logic          is_page_op;

    spi_byte_rx #(.SYNC_STAGES(SYNC_STAGES)) u_rx (
        .clk         (clk),
        .rst         (rst),
        .spi_cs_n    (spi_cs_n),
        .spi_sclk    (spi_sclk),
        .spi_mosi    (spi_mosi),
        .spi_dc      (spi_dc),
        .oled_res_n  (oled_res_n),
        .res_active  (res_active),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .byte_is_data(byte_is_data)
    );

    assign addr_mode = mode_q;

    // Column is set in two halves: 00-0F replaces bits [3:0], 10-17 replaces bits [6:4].
    always_comb begin
        col_lo_set      = 8'(col);
        col_lo_set[3:0] = byte_data[3:0];
        col_hi_set      = 8'(col);
        col_hi_set[6:4] = byte_data[2:0];
        is_page_op      = (byte_data[7:4] == OP_PAGE[7:4]) && ({1'b0, byte_data[3:0]} < PAGES_L);
    end

    always_ff @(posedge clk) begin
        if (rst || res_active) begin
            state          <= CMD_IDLE;
            pend_op        <= 8'd0;
            cmd_err        <= 1'b0;
            display_on     <= 1'b0;
            charge_pump_en <= 1'b0;
            mux_ratio      <= RST_MUX_RATIO;
            disp_offset    <= RST_DISP_OFS;
            start_line     <= RST_START_LINE;
            mode_q         <= RST_ADDR_MODE;
            page           <= '0;
            col            <= '0;
            pix_we         <= 1'b0;
            pix_page       <= '0;
            pix_col        <= '0;
            pix_data       <= 8'd0;
        end else begin
            cmd_err <= 1'b0;
            pix_we  <= 1'b0;
            if (byte_valid) begin
                if (byte_is_data) begin
                    // Data aborts a half-finished command but the write still happens.
                    if (state == CMD_ARG) begin
                        cmd_err <= 1'b1;
                        state   <= CMD_IDLE;
                    end
                    pix_we   <= 1'b1;
                    pix_page <= page;
                    pix_col  <= col;
                    pix_data <= byte_data;
                    case (mode_q)
                        ADDR_HORIZ: begin
                            col <= col + 1'b1;
                            if (&col) page <= page + 1'b1;
                        end
                        ADDR_VERT: begin
                            page <= page + 1'b1;
                            if (&page) col <= col + 1'b1;
                        end
                        default: col <= col + 1'b1;
                    endcase
                end else if (state == CMD_ARG) begin
                    state <= CMD_IDLE;
                    case (pend_op)
                        OP_MUX_RATIO: begin
                            if (byte_data[5:0] >= MUX_RATIO_MIN) mux_ratio <= byte_data[5:0];
                            else                                 cmd_err   <= 1'b1;
                        end
                        OP_DISP_OFS: disp_offset    <= byte_data[5:0];
                        OP_CHG_PUMP: charge_pump_en <= byte_data[2];
                        OP_ADDR_MODE: begin
                            if (byte_data[1:0] == 2'd3) cmd_err <= 1'b1;
                            else                        mode_q  <= addr_mode_e'(byte_data[1:0]);
                        end
                        default: ;
                    endcase
                end else begin
                    if (byte_data == OP_DISP_OFF)            display_on <= 1'b0;
                    else if (byte_data == OP_DISP_ON)        display_on <= 1'b1;
                    else if (byte_data[7:6] == OP_START_LINE[7:6]) start_line <= byte_data[5:0];
                    else if (is_page_op)                     page <= byte_data[PW-1:0];
                    else if (byte_data[7:4] == 4'h0)         col  <= col_lo_set[CW-1:0];
                    else if (byte_data[7:3] == 5'b00010)     col  <= col_hi_set[CW-1:0];
                    else if (takes_arg(byte_data)) begin
                        pend_op <= byte_data;
                        state   <= CMD_ARG;
                    end else begin
                        cmd_err <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_oled_cmd_receiver.sv
module tb_oled_cmd_receiver;
    import oled_pkg::*;

    localparam int SS    = 2;
    localparam int COLS  = 128;
    localparam int PAGES = 8;
    localparam int HALF  = 3;     // SCLK half period in clk cycles (period 6 clk)

    logic clk = 1'b0, rst = 1'b1;
    logic spi_cs_n = 1'b1, spi_sclk = 1'b0, spi_mosi = 1'b0, spi_dc = 1'b0, oled_res_n = 1'b1;
    logic byte_valid, byte_is_data, cmd_err, display_on, charge_pump_en, pix_we;
    logic [7:0] byte_data, pix_data;
    logic [5:0] mux_ratio, disp_offset, start_line;
    logic [1:0] addr_mode;
    logic [2:0] pix_page;
    logic [6:0] pix_col;

    oled_cmd_receiver #(.SYNC_STAGES(SS), .COLS(COLS), .PAGES(PAGES)) dut (
        .clk(clk), .rst(rst), .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
        .spi_dc(spi_dc), .oled_res_n(oled_res_n), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_is_data(byte_is_data), .cmd_err(cmd_err), .display_on(display_on),
        .charge_pump_en(charge_pump_en), .mux_ratio(mux_ratio), .disp_offset(disp_offset),
        .start_line(start_line), .addr_mode(addr_mode), .pix_we(pix_we), .pix_page(pix_page),
        .pix_col(pix_col), .pix_data(pix_data)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model: controller behaviour in plain arithmetic ----------------
    int m_disp, m_cp, m_mux, m_off, m_start, m_mode, m_page, m_col, m_pend, m_byte, m_isd;
    int n_bytes = 0, n_err = 0;
    logic [31:0] exp_wr[$];
    logic [31:0] exp_byte[$];

    function automatic void model_reset();
        m_disp = 0; m_cp = 0; m_mux = 63; m_off = 0; m_start = 0; m_mode = 2;
        m_page = 0; m_col = 0; m_pend = -1; m_byte = 0; m_isd = 0;
    endfunction

    function automatic void model_byte(input int is_d, input int b);
        int lin;
        n_bytes++;
        m_byte = b;
        m_isd  = is_d;
        exp_byte.push_back(32'((is_d << 8) | b));
        if (is_d != 0) begin
            if (m_pend >= 0) begin n_err++; m_pend = -1; end
            exp_wr.push_back(32'((m_page << 15) | (m_col << 8) | b));
            if (m_mode == 0) begin
                lin = (m_page * COLS + m_col + 1) % (COLS * PAGES);
                m_page = lin / COLS; m_col = lin % COLS;
            end else if (m_mode == 1) begin
                lin = (m_col * PAGES + m_page + 1) % (COLS * PAGES);
                m_col = lin / PAGES; m_page = lin % PAGES;
            end else begin
                m_col = (m_col + 1) % COLS;
            end
        end else if (m_pend >= 0) begin
            if (m_pend == 'hA8) begin
                if ((b % 64) >= 15) m_mux = b % 64; else n_err++;
            end else if (m_pend == 'hD3) m_off = b % 64;
            else if (m_pend == 'h8D) m_cp = (b / 4) % 2;
            else if ((b % 4) == 3) n_err++;
            else m_mode = b % 4;
            m_pend = -1;
        end else begin
            if (b == 'hAE) m_disp = 0;
            else if (b == 'hAF) m_disp = 1;
            else if (b >= 'h40 && b <= 'h7F) m_start = b - 'h40;
            else if (b >= 'hB0 && b < 'hB0 + PAGES) m_page = b - 'hB0;
            else if (b <= 'h0F) m_col = (m_col / 16) * 16 + b;
            else if (b >= 'h10 && b <= 'h17) m_col = (m_col % 16) + (b - 'h10) * 16;
            else if (b == 'hA8 || b == 'hD3 || b == 'h8D || b == 'h20) m_pend = b;
            else n_err++;
        end
    endfunction

    // ---------------- monitor ----------------
    int bv_cnt = 0, err_cnt = 0, last_rise = 0, bv_cyc = 0;
    always @(negedge clk) begin
        if (byte_valid) begin
            bv_cnt++;
            bv_cyc = cyc;
            chk("bv_latency", 32'(cyc - last_rise), 32'(SS + 1));
            if (exp_byte.size() == 0) chk("byte_unexpected", 32'(byte_data), 32'hFFFF_FFFF);
            else chk("byte", {23'd0, byte_is_data, byte_data}, exp_byte.pop_front());
        end
        if (cmd_err) err_cnt++;
        if (pix_we) begin
            chk("pix_latency", 32'(cyc - bv_cyc), 32'd1);
            if (exp_wr.size() == 0) chk("pix_unexpected", {14'd0, pix_page, pix_col, pix_data}, 32'hFFFF_FFFF);
            else chk("pix_write", {14'd0, pix_page, pix_col, pix_data}, exp_wr.pop_front());
        end
    end

    // ---------------- drivers ----------------
    task automatic spi_send(input int is_d, input int bin, input int nbits, input bit do_model);
        int b;
        b = bin & 255;
        spi_cs_n = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            spi_sclk = 1'b0;
            spi_mosi = b[7-i];
            spi_dc   = is_d[0];
            repeat (HALF - 1) @(negedge clk);
            @(negedge clk);
            spi_sclk = 1'b1;
            if (i == 7 && do_model) begin
                last_rise = cyc;
                model_byte(is_d, b);
            end
            repeat (HALF - 1) @(negedge clk);
        end
        @(negedge clk);
        spi_sclk = 1'b0;
    endtask

    task automatic cmd(input int b);
        spi_send(0, b, 8, 1'b1);
    endtask

    task automatic dat(input int b);
        spi_send(1, b, 8, 1'b1);
    endtask

    task automatic cs_high();
        @(negedge clk);
        spi_sclk = 1'b0;
        spi_cs_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic check_regs(input string tag);
        repeat (8) @(negedge clk);
        chk({tag, ".display_on"},  32'(display_on),     32'(m_disp));
        chk({tag, ".charge_pump"}, 32'(charge_pump_en), 32'(m_cp));
        chk({tag, ".mux_ratio"},   32'(mux_ratio),      32'(m_mux));
        chk({tag, ".disp_offset"}, 32'(disp_offset),    32'(m_off));
        chk({tag, ".start_line"},  32'(start_line),     32'(m_start));
        chk({tag, ".addr_mode"},   32'(addr_mode),      32'(m_mode));
        chk({tag, ".byte_data"},   32'(byte_data),      32'(m_byte));
        chk({tag, ".byte_is_dat"}, 32'(byte_is_data),   32'(m_isd));
    endtask

    int bv0, e0, r, sel;

    initial begin
        model_reset();
        repeat (5) @(negedge clk);
        rst = 1'b0;
        check_regs("reset");
        chk("reset.strobes", {29'd0, byte_valid, cmd_err, pix_we}, 32'd0);

        // power-on sequence
        bv0 = bv_cnt; e0 = err_cnt;
        cmd('hAE); cmd('hA8); cmd('h3F); cmd('hD3); cmd('h00); cmd('h40);
        cmd('h8D); cmd('h14); cmd('h20); cmd('h00); cmd('hAF);
        cs_high();
        check_regs("pwr");
        chk("pwr.bv_count", 32'(bv_cnt - bv0), 32'd11);
        chk("pwr.no_err",   32'(err_cnt - e0), 32'd0);
        chk("pwr.disp_lit", 32'(display_on), 32'd1);
        chk("pwr.mode_lit", 32'(addr_mode), 32'd0);
        chk("pwr.cp_lit",   32'(charge_pump_en), 32'd1);

        // horizontal wrap from (0,126): writes (0,126) (0,127) (1,0)
        cmd('hB0); cmd('h0E); cmd('h17);
        for (int i = 0; i < 3; i++) dat($urandom_range(0, 255));

        // vertical wrap from (7,127): writes (7,127) (0,0)
        cmd('h20); cmd('h01); cmd('hB7); cmd('h0F); cmd('h17);
        for (int i = 0; i < 2; i++) dat($urandom_range(0, 255));
        cs_high();
        check_regs("vert");

        // illegal commands
        e0 = err_cnt;
        cmd('h20); cmd('h03);
        cmd('hA8); cmd('h05);
        cmd('hE3);
        cmd('hA8); dat('h55);
        cs_high();
        check_regs("illegal");
        chk("illegal.err_count", 32'(err_cnt - e0), 32'd4);
        chk("illegal.mode_kept", 32'(addr_mode), 32'd1);
        chk("illegal.mux_kept",  32'(mux_ratio), 32'd63);

        // CS abort of a partial byte
        cmd('hAE); cs_high();
        bv0 = bv_cnt;
        spi_send(0, 'hFF, 5, 1'b0);
        cs_high();
        cmd('hAF); cs_high();
        check_regs("abort");
        chk("abort.bv_count", 32'(bv_cnt - bv0), 32'd1);

        // randomized traffic
        for (int k = 0; k < 80; k++) begin
            r = $urandom_range(0, 99);
            if (r < 40) dat($urandom_range(0, 255));
            else if (r < 90) begin
                sel = $urandom_range(0, 9);
                case (sel)
                    0: cmd($urandom_range(0, 1) ? 'hAF : 'hAE);
                    1: cmd('h40 + $urandom_range(0, 63));
                    2: cmd('hB0 + $urandom_range(0, 15));
                    3: cmd($urandom_range(0, 'h17));
                    4: begin cmd('hA8); cmd($urandom_range(0, 255)); end
                    5: begin cmd('hD3); cmd($urandom_range(0, 255)); end
                    6: begin cmd('h8D); cmd($urandom_range(0, 255)); end
                    7: begin cmd('h20); cmd($urandom_range(0, 3)); end
                    8: cmd('h20);
                    default: cmd($urandom_range(0, 255));
                endcase
            end else begin
                spi_send(0, $urandom_range(0, 255), $urandom_range(1, 7), 1'b0);
                cs_high();
            end
            if (k % 10 == 9) check_regs("rand");
        end
        cs_high();

        // OLED reset low in the middle of a data byte
        cmd('hAF); cmd('h20); cmd('h00); cmd('hB3); cmd('hD3); cmd('h21); dat('h5A);
        repeat (8) @(negedge clk);
        spi_send(1, 'hC3, 4, 1'b0);
        oled_res_n = 1'b0;
        repeat (6) @(negedge clk);
        oled_res_n = 1'b1;
        model_reset();
        check_regs("res_n");
        chk("res_n.mux_lit", 32'(mux_ratio), 32'd63);
        chk("res_n.mode_lit", 32'(addr_mode), 32'd2);
        // CS stayed low: the next byte must still be aligned, and the pointer starts at (0,0)
        cmd('hAF); dat('h81);
        cs_high();
        check_regs("res_n.after");

        // rst held while SCLK toggles
        cmd('hAF); cmd('h8D); cmd('h14); cmd('h40 + 9);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        spi_send(1, 'hA5, 8, 1'b0);
        spi_send(0, 'hAE, 5, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        cs_high();
        check_regs("rst_sclk");

        repeat (10) @(negedge clk);
        chk("end.bv_total",  32'(bv_cnt), 32'(n_bytes));
        chk("end.err_total", 32'(err_cnt), 32'(n_err));
        chk("end.wr_left",   32'(exp_wr.size()), 32'd0);
        chk("end.byte_left", 32'(exp_byte.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
